// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Optional signed mode is enabled by defining SEQ_DIVIDER_SIGNED_EN.
module seq_divider32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ctl0,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             DivZero,
  output logic             Overflow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] q_work, q_work_n;
  // Working remainder is always below the divisor between iterations, so its top bit is never stored.
  logic [WIDTH-1:0] r_work, r_work_n;
  logic [WIDTH-1:0] b_work, b_work_n;
  logic [CW-1:0]    count, count_n;
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic             dz_pend, dz_pend_n;
  logic             ov_pend, ov_pend_n;
  logic [WIDTH-1:0] quotient_n, remainder_n;
  logic             busy_n, done_n, div_zero_n, overflow_n;

  logic             signed_mode;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_shift, trial;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign signed_mode = ctl0;
`else
  logic unused_ctl0;
  assign unused_ctl0 = ctl0;
  assign signed_mode = 1'b0;
`endif

  assign a_mag = (signed_mode && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign b_mag = (signed_mode && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

  // Shift-and-subtract step: R - B formed as R + ~B + 1 over WIDTH+1 bits.
  assign r_shift = {r_work, q_work[WIDTH-1]};
  assign trial   = r_shift + {1'b1, ~b_work} + (WIDTH+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      q_work    <= '0;
      r_work    <= '0;
      b_work    <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz_pend   <= 1'b0;
      ov_pend   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      DivZero   <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      q_work    <= q_work_n;
      r_work    <= r_work_n;
      b_work    <= b_work_n;
      count     <= count_n;
      neg_q     <= neg_q_n;
      neg_r     <= neg_r_n;
      dz_pend   <= dz_pend_n;
      ov_pend   <= ov_pend_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
      busy      <= busy_n;
      done      <= done_n;
      DivZero   <= div_zero_n;
      Overflow  <= overflow_n;
    end
  end

  always_comb begin
    state_n     = state;
    q_work_n    = q_work;
    r_work_n    = r_work;
    b_work_n    = b_work;
    count_n     = count;
    neg_q_n     = neg_q;
    neg_r_n     = neg_r;
    dz_pend_n   = dz_pend;
    ov_pend_n   = ov_pend;
    quotient_n  = quotient;
    remainder_n = remainder;
    busy_n      = busy;
    done_n      = 1'b0;
    div_zero_n  = DivZero;
    overflow_n  = Overflow;

    case (state)
      S_IDLE: begin
        if (start) begin
          busy_n = 1'b1;
          if (B == '0) begin
            q_work_n  = '1;
            r_work_n  = A;
            neg_q_n   = 1'b0;
            neg_r_n   = 1'b0;
            dz_pend_n = 1'b1;
            ov_pend_n = 1'b0;
            state_n   = S_FIN;
          end else begin
            q_work_n  = a_mag;
            r_work_n  = '0;
            b_work_n  = b_mag;
            count_n   = '0;
            neg_q_n   = signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r_n   = signed_mode && A[WIDTH-1];
            dz_pend_n = 1'b0;
            ov_pend_n = signed_mode && (A == MIN_NEG) && (B == '1);
            state_n   = S_RUN;
          end
        end
      end
      S_RUN: begin
        q_work_n = {q_work[WIDTH-2:0], ~trial[WIDTH]};
        r_work_n = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        count_n  = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          state_n = S_FIN;
        end
      end
      S_FIN: begin
        quotient_n  = neg_q ? (~q_work + WIDTH'(1)) : q_work;
        remainder_n = neg_r ? (~r_work + WIDTH'(1)) : r_work;
        div_zero_n  = dz_pend;
        overflow_n  = ov_pend;
        done_n      = 1'b1;
        busy_n      = 1'b0;
        state_n     = S_IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_divider32.sv
// Directed self-checking bench for seq_divider32 (signed cases when SEQ_DIVIDER_SIGNED_EN is defined).
module tb_seq_divider32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        mode;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_zero, overflow;

  int compared = 0;
  int mismatched = 0;

  seq_divider32 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .A         (op_a),
    .B         (op_b),
    .ctl0      (mode),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .DivZero   (div_zero),
    .Overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done; lat = -1 on timeout.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                       output int lat, output bit busy_ok);
    @(negedge clk);
    op_a = a; op_b = b; mode = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'h0;
    lat = -1;
    busy_ok = busy;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    compared++; if (quotient !== 32'h0) begin mismatched++; $display("FAIL reset_quotient got %h want %h", quotient, 32'h0); end
    compared++; if (remainder !== 32'h0) begin mismatched++; $display("FAIL reset_remainder got %h want %h", remainder, 32'h0); end
    compared++; if ({busy, done, div_zero, overflow} !== 4'b0000) begin mismatched++; $display("FAIL reset_flags got %b want 0000", {busy, done, div_zero, overflow}); end
  endtask

  task automatic test_basic;
    int lat; bit bok;
    do_op(32'd100, 32'd7, 1'b0, lat, bok);
    compared++; if (lat !== 33) begin mismatched++; $display("FAIL basic_latency got %0d want 33", lat); end
    compared++; if (quotient !== 32'd14) begin mismatched++; $display("FAIL basic_quotient got %0d want 14", quotient); end
    compared++; if (remainder !== 32'd2) begin mismatched++; $display("FAIL basic_remainder got %0d want 2", remainder); end
    compared++; if (div_zero !== 1'b0) begin mismatched++; $display("FAIL basic_divzero got %b want 0", div_zero); end
    compared++; if (bok !== 1'b1) begin mismatched++; $display("FAIL basic_busy_during got %b want 1", bok); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    @(posedge clk); #1;
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_extremes;
    int lat; bit bok;
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, bok);
    compared++; if (lat !== 33) begin mismatched++; $display("FAIL max_div1_latency got %0d want 33", lat); end
    compared++; if (quotient !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL max_div1_quotient got %h want ffffffff", quotient); end
    compared++; if (remainder !== 32'h0) begin mismatched++; $display("FAIL max_div1_remainder got %h want 0", remainder); end
    do_op(32'd5, 32'hFFFF_FFFF, 1'b0, lat, bok);
    compared++; if (quotient !== 32'h0) begin mismatched++; $display("FAIL small_by_max_quotient got %h want 0", quotient); end
    compared++; if (remainder !== 32'd5) begin mismatched++; $display("FAIL small_by_max_remainder got %h want 5", remainder); end
  endtask

  task automatic test_div_zero;
    int lat; bit bok;
    do_op(32'd5, 32'd0, 1'b0, lat, bok);
    compared++; if (lat !== 1) begin mismatched++; $display("FAIL dz_latency got %0d want 1", lat); end
    compared++; if (quotient !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL dz_quotient got %h want ffffffff", quotient); end
    compared++; if (remainder !== 32'd5) begin mismatched++; $display("FAIL dz_remainder got %h want 5", remainder); end
    compared++; if (div_zero !== 1'b1) begin mismatched++; $display("FAIL dz_flag got %b want 1", div_zero); end
    do_op(32'd9, 32'd3, 1'b0, lat, bok);
    compared++; if (quotient !== 32'd3) begin mismatched++; $display("FAIL after_dz_quotient got %h want 3", quotient); end
    compared++; if (remainder !== 32'd0) begin mismatched++; $display("FAIL after_dz_remainder got %h want 0", remainder); end
    compared++; if (div_zero !== 1'b0) begin mismatched++; $display("FAIL after_dz_flag got %b want 0", div_zero); end
  endtask

  task automatic test_abort;
    int lat; bit bok; bit seen_done;
    bit busy_mid;
    seen_done = 1'b0;
    busy_mid = 1'b0;
    @(negedge clk);
    op_a = 32'd100; op_b = 32'd7; mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
      start = 1'b0;
      if (n == 15) busy_mid = busy;
      if (n == 9) begin
        op_a = 32'd50; op_b = 32'd5; start = 1'b1;
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    compared++; if (busy_mid !== 1'b1) begin mismatched++; $display("FAIL abort_busy_mid got %b want 1", busy_mid); end
    compared++; if (quotient !== 32'h0) begin mismatched++; $display("FAIL abort_quotient got %h want 0", quotient); end
    compared++; if (remainder !== 32'h0) begin mismatched++; $display("FAIL abort_remainder got %h want 0", remainder); end
    compared++; if ({busy, done, div_zero, overflow} !== 4'b0000) begin mismatched++; $display("FAIL abort_flags got %b want 0000", {busy, done, div_zero, overflow}); end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    compared++; if (seen_done !== 1'b0) begin mismatched++; $display("FAIL abort_no_done got %b want 0", seen_done); end
    do_op(32'd100, 32'd7, 1'b0, lat, bok);
    compared++; if (lat !== 33) begin mismatched++; $display("FAIL restart_latency got %0d want 33", lat); end
    compared++; if ({quotient, remainder} !== {32'd14, 32'd2}) begin mismatched++; $display("FAIL restart_result got %h/%h want e/2", quotient, remainder); end
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed;
    int lat; bit bok;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bok);
    compared++; if (lat !== 33) begin mismatched++; $display("FAIL ovf_latency got %0d want 33", lat); end
    compared++; if (quotient !== 32'h8000_0000) begin mismatched++; $display("FAIL ovf_quotient got %h want 80000000", quotient); end
    compared++; if (remainder !== 32'h0) begin mismatched++; $display("FAIL ovf_remainder got %h want 0", remainder); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag got %b want 1", overflow); end
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bok);
    compared++; if (quotient !== 32'hFFFF_FFFD) begin mismatched++; $display("FAIL neg7_by_2_quotient got %h want fffffffd", quotient); end
    compared++; if (remainder !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL neg7_by_2_remainder got %h want ffffffff", remainder); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL neg7_by_2_overflow got %b want 0", overflow); end
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat, bok);
    compared++; if (quotient !== 32'hFFFF_FFFD) begin mismatched++; $display("FAIL 7_by_neg2_quotient got %h want fffffffd", quotient); end
    compared++; if (remainder !== 32'd1) begin mismatched++; $display("FAIL 7_by_neg2_remainder got %h want 1", remainder); end
  endtask
`else
  task automatic test_signed;
    int lat; bit bok;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bok);
    compared++; if (quotient !== 32'h7FFF_FFFC) begin mismatched++; $display("FAIL ctl0_ignored_quotient got %h want 7ffffffc", quotient); end
    compared++; if (remainder !== 32'd1) begin mismatched++; $display("FAIL ctl0_ignored_remainder got %h want 1", remainder); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL ctl0_ignored_overflow got %b want 0", overflow); end
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bok);
    compared++; if ({quotient, remainder, overflow} !== {32'h0, 32'h8000_0000, 1'b0}) begin mismatched++; $display("FAIL ctl0_ignored_minneg got %h/%h/%b want 0/80000000/0", quotient, remainder, overflow); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_abort();
    test_signed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_divider32.md
Name: seq_divider32

Overview:
- Multi-cycle 32-bit restoring divider; the inverse-operation companion to the combinational add/sub datapath in the vALU.
- Computes quotient and remainder of A / B by iterative shift-and-subtract, one quotient bit per clock.
- Uses a start/busy/done handshake so the surrounding ALU control can stall while the block runs.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; the iteration counter is sized to log2(WIDTH)+1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  32  dividend
- B  input  32  divisor
- ctl0  input  1  1 = signed divide, 0 = unsigned (see Optional Feature)
- quotient  output  32  registered quotient
- remainder  output  32  registered remainder
- busy  output  1  high in RUN and FIN
- done  output  1  one-cycle pulse when results are valid
- DivZero  output  1  divisor was zero for the last completed operation
- Overflow  output  1  signed overflow case for the last completed operation

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: at a clk edge with reset=1, state=IDLE and quotient, remainder, busy, done, DivZero, Overflow = 0. Reset overrides start and aborts any operation in progress with no partial result.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 and B!=0: latch A, B and mode; clear working remainder R (33-bit) and count; go to RUN.
  - start=1 and B==0: go to FIN with quotient=32'hFFFFFFFF, remainder=A, DivZero=1.
  - start=0: hold. Outputs keep the last results.
- RUN, each cycle:
  - R = {R[31:0], Q[31]}, Q = Q << 1.
  - T = R - {1'b0, |B|}, using the 33-bit add of ~B plus carry-in 1 (same add/sub method as the ALU).
  - If T[32]==0: R = T and Q[0] = 1. Otherwise R is unchanged and Q[0] = 0.
  - count++. After 32 iterations, go to FIN.
- FIN: register quotient/remainder (sign-corrected if signed), set flags, assert done for exactly this one cycle, then go to IDLE. busy=0 from the next cycle.
- Latency: start sampled at edge k gives done=1 during the cycle after edge k+33. For divide-by-zero, done=1 after edge k+1.
- start while busy=1 is ignored; it is not queued.
- A and B may change after the start edge; the latched copies are used.
- DivZero and Overflow update only in FIN and hold until the next FIN.
- Unsigned results: quotient=floor(A/B), remainder=A-quotient*B.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - ctl0=1 selects signed mode. Operands are converted to magnitudes before RUN.
  - Quotient is negated when the operand signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - A=32'h80000000, B=32'hFFFFFFFF gives quotient=32'h80000000, remainder=0, Overflow=1, with normal 33-cycle latency.
  - Divide-by-zero behaves as in unsigned mode.
- Undefined: ctl0 is ignored, all divides are unsigned, and Overflow is tied to 0.

Test Plan:
- Reset, then A=100, B=7, start pulse: done exactly 33 cycles after the start edge, quotient=14, remainder=2, DivZero=0, busy high throughout.
- A=32'hFFFFFFFF, B=1: quotient=32'hFFFFFFFF, remainder=0. Then A=5, B=32'hFFFFFFFF: quotient=0, remainder=5.
- A=5, B=0: done one cycle after start, quotient=32'hFFFFFFFF, remainder=5, DivZero=1. A following 9/3 gives quotient=3 and clears DivZero.
- Start 100/7, pulse start with 50/5 at cycle 10, assert reset at cycle 20: second start is ignored, after reset all outputs=0 and state=IDLE, no done pulse; a new 100/7 completes normally.
- SEQ_DIVIDER_SIGNED_EN, ctl0=1:
  - -7/2 gives quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF.
  - 7/-2 gives quotient=32'hFFFFFFFD, remainder=1.
  - 32'h80000000/-1 gives Overflow=1, quotient=32'h80000000.
- Without the macro, ctl0=1 with -7/2 gives the unsigned result quotient=32'h7FFFFFFC, remainder=1, Overflow=0.
